// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - shared state encoding, default cycle counts and image indices for the warmboot sequencer
package warmboot_pkg;

  typedef enum logic [2:0] {
    ST_ATTACH_WAIT = 3'd0,
    ST_IDLE        = 3'd1,
    ST_DETACH      = 3'd2,
    ST_SETUP       = 3'd3,
    ST_BOOT        = 3'd4
  } state_e;

  // Defaults assume the 48 MHz USB clock.
  localparam int unsigned DEF_ATTACH_CYCLES  = 48000;
  localparam int unsigned DEF_DETACH_CYCLES  = 480000;
  localparam int unsigned DEF_SETUP_CYCLES   = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 480000000;

  localparam logic [1:0] IMG_BOOTLOADER = 2'd0;
  localparam logic [1:0] IMG_USER       = 2'd1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/warmboot_timer.sv
// rtl/warmboot_timer.sv - loadable down-counter with a registered zero flag
module warmboot_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  // zero_q tracks count_q == 0, except straight out of reset where the
  // counter is unloaded and must not read as expired.
  always_comb begin
    count_d = count_q;
    zero_d  = zero_q;
    if (load_i) begin
      count_d = load_val_i;
      zero_d  = (load_val_i == '0);
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
      zero_d  = (count_q == WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - USB pull-up and SB_WARMBOOT sequencing; WARMBOOT_SEQ_TIMEOUT_EN adds idle auto-boot
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int unsigned ATTACH_CYCLES  = DEF_ATTACH_CYCLES,
  parameter int unsigned DETACH_CYCLES  = DEF_DETACH_CYCLES,
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [1:0]  TIMEOUT_IMG    = IMG_USER
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       boot_req,
  input  logic [1:0] boot_img,
  input  logic       usb_activity,
  output logic       usb_pu_en,
  output logic [1:0] wb_s,
  output logic       wb_boot,
  output logic       busy,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_PHASE = max_u(max_u(ATTACH_CYCLES, DETACH_CYCLES), SETUP_CYCLES);
`ifdef WARMBOOT_SEQ_TIMEOUT_EN
  localparam int unsigned MAX_CYC = max_u(MAX_PHASE, TIMEOUT_CYCLES);
`else
  localparam int unsigned MAX_CYC = MAX_PHASE;
`endif
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  // Loading N-1 on the entry edge makes each phase last exactly N cycles.
  localparam logic [CW-1:0] ATTACH_LD = CW'(ATTACH_CYCLES - 1);
  localparam logic [CW-1:0] DETACH_LD = CW'(DETACH_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      img_q, img_d;
  logic            armed_q;
  logic            ph_load, ph_zero;
  logic [CW-1:0]   ph_val;
  logic            req;
  logic [1:0]      req_img;
  logic            pu_q, wb_boot_q, busy_q;
  logic [1:0]      wb_s_q;

  warmboot_timer #(.WIDTH(CW)) u_phase_timer (
    .clk_i      (clk_48mhz),
    .rst_ni     (reset_n),
    .load_i     (ph_load),
    .en_i       (1'b1),
    .load_val_i (ph_val),
    .zero_o     (ph_zero)
  );

  // Reset itself counts as entering ATTACH_WAIT; armed_q loads the first phase.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    ph_load = 1'b0;
    ph_val  = '0;
    case (state_q)
      ST_ATTACH_WAIT: begin
        if (!armed_q) begin
          ph_load = 1'b1;
          ph_val  = ATTACH_LD;
        end else if (ph_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req) begin
          state_d = ST_DETACH;
          img_d   = req_img;
          ph_load = 1'b1;
          ph_val  = DETACH_LD;
        end
      end
      ST_DETACH: begin
        if (ph_zero) begin
          state_d = ST_SETUP;
          ph_load = 1'b1;
          ph_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (ph_zero) state_d = ST_BOOT;
      end
      ST_BOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_ATTACH_WAIT;
        ph_load = 1'b1;
        ph_val  = ATTACH_LD;
      end
    endcase
  end

`ifdef WARMBOOT_SEQ_TIMEOUT_EN
  logic tmo_load, tmo_zero, tmo_expired;

  assign tmo_load    = (state_d == ST_IDLE) && ((state_q != ST_IDLE) || usb_activity);
  assign tmo_expired = (state_q == ST_IDLE) && tmo_zero;

  warmboot_timer #(.WIDTH(CW)) u_timeout_timer (
    .clk_i      (clk_48mhz),
    .rst_ni     (reset_n),
    .load_i     (tmo_load),
    .en_i       (state_q == ST_IDLE),
    .load_val_i (CW'(TIMEOUT_CYCLES - 1)),
    .zero_o     (tmo_zero)
  );

  // An explicit request in the expiry cycle keeps its own image.
  assign req     = boot_req | tmo_expired;
  assign req_img = boot_req ? boot_img : TIMEOUT_IMG;
`else
  logic unused_tmo;
  assign unused_tmo = usb_activity ^ (TIMEOUT_CYCLES != 0) ^ (TIMEOUT_IMG != 2'd0);
  assign req        = boot_req;
  assign req_img    = boot_img;
`endif

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ATTACH_WAIT;
      img_q     <= 2'd0;
      armed_q   <= 1'b0;
      pu_q      <= 1'b0;
      wb_s_q    <= 2'd0;
      wb_boot_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      armed_q   <= 1'b1;
      pu_q      <= (state_d == ST_IDLE);
      wb_s_q    <= ((state_d == ST_SETUP) || (state_d == ST_BOOT)) ? img_d : 2'd0;
      wb_boot_q <= (state_d == ST_BOOT);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign usb_pu_en = pu_q;
  assign wb_s      = wb_s_q;
  assign wb_boot   = wb_boot_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule
